// File: rtl/data_mem_responder.sv
// Handshaked single-beat data memory slave with programmable wait states.
// Optional DMEM_ACCESS_CNT_EN adds saturating load/store completion counters.
module data_mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
`ifdef DMEM_ACCESS_CNT_EN
    ,
    output logic [15:0]       ld_cnt,
    output logic [15:0]       st_cnt
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam int          IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_U   = 32'(DEPTH);
    localparam bit          ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [3:0]  CNT_INIT  = 4'(WAIT_CYCLES);

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              valid_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              accept;
    logic              commit;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic              rsp_hs;

    function automatic logic [DATA_W-1:0] img(input int i);
        if (i == 0) return DATA_W'(8'hEC);
        if (i == 1) return DATA_W'(8'h0A);
        if (i == 2) return DATA_W'(8'h02);
        return '0;
    endfunction

    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && req_ready;
    assign rsp_hs    = valid_q && rsp_ready;

    // With no wait states the commit happens on the accept edge itself,
    // so the live request fields are used instead of the latched copy.
    assign c_we     = ZERO_WAIT ? req_we    : we_q;
    assign c_addr   = ZERO_WAIT ? req_addr  : addr_q;
    assign c_wdata  = ZERO_WAIT ? req_wdata : wdata_q;
    assign in_range = 32'(c_addr) < DEPTH_U;
    assign idx      = c_addr[IDX_W-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (ZERO_WAIT) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    commit  = 1'b1;
                    cnt_d   = 4'd0;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (commit) begin
            valid_q <= 1'b1;
            rdata_q <= (!c_we && in_range) ? mem_q[idx] : '0;
            err_q   <= !in_range;
        end else if (rsp_hs) begin
            valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= img(i);
        end else if (commit && c_we && in_range) begin
            mem_q[idx] <= c_wdata;
        end
    end

    assign rsp_valid = valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

`ifdef DMEM_ACCESS_CNT_EN
    logic [15:0] ld_cnt_q, st_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_cnt_q <= 16'd0;
            st_cnt_q <= 16'd0;
        end else if (rsp_hs && !err_q) begin
            if (!we_q && ld_cnt_q != 16'hFFFF) ld_cnt_q <= ld_cnt_q + 16'd1;
            if (we_q && st_cnt_q != 16'hFFFF) st_cnt_q <= st_cnt_q + 16'd1;
        end
    end

    assign ld_cnt = ld_cnt_q;
    assign st_cnt = st_cnt_q;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: vector table with scoreboard, plus
// hold, reset-in-flight and zero-wait-state sequences.
module tb_data_mem_responder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_ready, req_we;
    logic [7:0] req_addr, req_wdata;
    logic       rsp_valid, rsp_ready, rsp_err;
    logic [7:0] rsp_rdata;

    logic       z_req_valid, z_req_ready, z_req_we;
    logic [7:0] z_req_addr, z_req_wdata;
    logic       z_rsp_valid, z_rsp_ready, z_rsp_err;
    logic [7:0] z_rsp_rdata;

`ifdef DMEM_ACCESS_CNT_EN
    logic [15:0] ld_cnt, st_cnt, z_ld_cnt, z_st_cnt;
`endif

    always #5 clk = ~clk;

    data_mem_responder #(.WAIT_CYCLES(2)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
`ifdef DMEM_ACCESS_CNT_EN
        , .ld_cnt(ld_cnt), .st_cnt(st_cnt)
`endif
    );

    data_mem_responder #(.WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
        .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
`ifdef DMEM_ACCESS_CNT_EN
        , .ld_cnt(z_ld_cnt), .st_cnt(z_st_cnt)
`endif
    );

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        logic       err;
    } vec_t;

    typedef struct packed {
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vt[16];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Scoreboard consumer: compares on the cycle the response handshake occurs.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_rdata", rsp_rdata, mon_e.rdata);
                chk("rsp_err", rsp_err, mon_e.err);
            end
        end
    end

    task automatic do_req(input logic we, input logic [7:0] a,
                          input logic [7:0] d, input logic [7:0] er,
                          input logic ee, input int hold);
        int n;
        bit ok;
        @(posedge clk); #1;
        rsp_ready = (hold == 0);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            chk("accept_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        sb.push_back('{er, ee});
        #1;
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = 8'($urandom);
        req_wdata = 8'($urandom);
        n  = 0;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (rsp_valid) begin ok = 1; break; end
        end
        if (!ok) begin
            chk("rsp_timeout", 0, 1);
            return;
        end
        chk("latency", n, 3);
        for (int i = 0; i < hold; i++) begin
            chk("hold_valid", rsp_valid, 1);
            chk("hold_rdata", rsp_rdata, er);
            chk("hold_req_ready", req_ready, 0);
            @(negedge clk);
        end
        if (hold > 0) begin
            @(posedge clk); #1;
            rsp_ready = 1'b1;
        end
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!rsp_valid) begin ok = 1; break; end
        end
        if (!ok) chk("release_timeout", 0, 1);
    endtask

    initial begin
        logic [7:0] img [8];
        int exp_ld;
        int exp_st;
        int last_acc;
        int nacc;

        img = '{8'hEC, 8'h0A, 8'h02, 8'h33, 8'h00, 8'h55, 8'h00, 8'h00};
        vt[0] = '{1'b0, 8'h00, 8'h00, 8'hEC, 1'b0};
        vt[1] = '{1'b1, 8'h05, 8'h55, 8'h00, 1'b0};
        vt[2] = '{1'b0, 8'h05, 8'h00, 8'h55, 1'b0};
        vt[3] = '{1'b0, 8'h20, 8'h00, 8'h00, 1'b1};
        vt[4] = '{1'b1, 8'h20, 8'hAA, 8'h00, 1'b1};
        vt[5] = '{1'b0, 8'h01, 8'h00, 8'h0A, 1'b0};
        vt[6] = '{1'b0, 8'h02, 8'h00, 8'h02, 1'b0};
        vt[7] = '{1'b1, 8'h03, 8'h33, 8'h00, 1'b0};
        for (int i = 0; i < 8; i++)
            vt[8+i] = '{1'b0, 8'(i), 8'h00, img[i], 1'b0};

        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0;
        z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = '0;
        z_req_wdata = '0; z_rsp_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_z_rsp_valid", z_rsp_valid, 0);
`ifdef DMEM_ACCESS_CNT_EN
        chk("rst_ld_cnt", ld_cnt, 0);
        chk("rst_st_cnt", st_cnt, 0);
`endif
        rst_n = 1'b1;

        exp_ld = 0;
        exp_st = 0;
        for (int i = 0; i < 16; i++) begin
            do_req(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].rdata,
                   vt[i].err, 0);
            if (!vt[i].err) begin
                if (vt[i].we) exp_st++;
                else exp_ld++;
            end
        end
`ifdef DMEM_ACCESS_CNT_EN
        chk("ld_cnt", ld_cnt, exp_ld);
        chk("st_cnt", st_cnt, exp_st);
`endif

        do_req(1'b0, 8'h01, 8'h00, 8'h0A, 1'b0, 4);

        // Reset while a store of FF to address 0 sits in WAIT.
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h00; req_wdata = 8'hFF;
        @(negedge clk);
        chk("mid_req_ready", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("mid_wait_ready", req_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", req_ready, 1);
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_rdata", rsp_rdata, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_req(1'b0, 8'h00, 8'h00, 8'hEC, 1'b0, 0);
        do_req(1'b0, 8'h05, 8'h00, 8'h00, 1'b0, 0);
`ifdef DMEM_ACCESS_CNT_EN
        chk("post_rst_ld_cnt", ld_cnt, 2);
        chk("post_rst_st_cnt", st_cnt, 0);
`endif
        chk("sb_drained", sb.size(), 0);

        // Zero wait states: continuous requests, one accepted every 2 cycles.
        @(posedge clk); #1;
        z_rsp_ready = 1'b1;
        z_req_valid = 1'b1; z_req_we = 1'b0; z_req_addr = 8'h02;
        last_acc = -10;
        nacc = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (z_rsp_valid) begin
                chk("z_latency", c, last_acc + 1);
                chk("z_rdata", z_rsp_rdata, 8'h02);
                chk("z_err", z_rsp_err, 0);
            end
            if (z_req_ready) begin
                if (nacc > 0) chk("z_spacing", c - last_acc, 2);
                last_acc = c;
                nacc++;
            end
        end
        z_req_valid = 1'b0;
        chk("z_accepts", nacc, 4);
        @(posedge clk); #1;
`ifdef DMEM_ACCESS_CNT_EN
        chk("z_ld_cnt", z_ld_cnt, 4);
`endif
        chk("z_idle", z_req_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
